// File: rtl/lkh_destport_queue.sv
// Per-VC FIFO of look-ahead destports: a header flit pushes its destport and
// the tail flit leaving the input buffer pops it.
module lkh_destport_queue #(
    parameter int V     = 4,
    parameter int DSTPw = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic                 hdr_flg_i,
    input  logic [V-1:0]         vc_num_i,
    input  logic [DSTPw-1:0]     lkdestport_i,
    input  logic [V-1:0]         pop_i,
    output logic [V*DSTPw-1:0]   destport_o,
    output logic [V-1:0]         destport_valid_o,
    output logic [V-1:0]         full_o,
    output logic                 err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DSTPw-1:0] mem_q    [V][DEPTH];
    logic [DSTPw-1:0] mem_d    [V][DEPTH];
    logic [PW-1:0]    wr_ptr_q [V];
    logic [PW-1:0]    wr_ptr_d [V];
    logic [PW-1:0]    rd_ptr_q [V];
    logic [PW-1:0]    rd_ptr_d [V];
    logic [CW-1:0]    cnt_q    [V];
    logic [CW-1:0]    cnt_d    [V];
    logic             err_q, err_d;

    logic             hdr_wr;
    logic             vc_onehot;
    logic             multi_vc;
    logic [V-1:0]     push_req, push_ok, pop_ok;

    // Explicit compare keeps the wrap correct for non-power-of-2 depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign hdr_wr    = wr_en_i & hdr_flg_i;
    assign vc_onehot = (vc_num_i != '0) && ((vc_num_i & (vc_num_i - V'(1))) == '0);
    assign multi_vc  = hdr_wr & (vc_num_i != '0) & ~vc_onehot;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | multi_vc;
        push_req = '0;
        push_ok  = '0;
        pop_ok   = '0;
        for (int i = 0; i < V; i++) begin
            push_req[i] = hdr_wr & vc_onehot & vc_num_i[i];
            pop_ok[i]   = pop_i[i] & (cnt_q[i] != '0);
            // A same-cycle pop frees the slot, so a push into a full queue is legal then.
            push_ok[i]  = push_req[i] & ((cnt_q[i] != FULL_CNT) | pop_ok[i]);
            if (push_ok[i]) begin
                mem_d[i][wr_ptr_q[i]] = lkdestport_i;
                wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
            end
            if (pop_ok[i]) begin
                rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            end
            cnt_d[i] = cnt_q[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
            if ((push_req[i] & ~push_ok[i]) | (pop_i[i] & ~pop_ok[i])) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is cleared too so destport_o reads 0 after reset, not stale data.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        destport_o       = '0;
        destport_valid_o = '0;
        full_o           = '0;
        for (int i = 0; i < V; i++) begin
            destport_o[i*DSTPw +: DSTPw] = mem_q[i][rd_ptr_q[i]];
            destport_valid_o[i]          = (cnt_q[i] != '0);
            full_o[i]                    = (cnt_q[i] == FULL_CNT);
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_lkh_destport_queue.sv
// Directed self-checking bench for lkh_destport_queue (V=4, DSTPw=4, DEPTH=2).
module tb_lkh_destport_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en_i, hdr_flg_i;
    logic [3:0]  vc_num_i;
    logic [3:0]  lkdestport_i;
    logic [3:0]  pop_i;
    logic [15:0] destport_o;
    logic [3:0]  destport_valid_o, full_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    lkh_destport_queue #(.V(4), .DSTPw(4), .DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en_i          (wr_en_i),
        .hdr_flg_i        (hdr_flg_i),
        .vc_num_i         (vc_num_i),
        .lkdestport_i     (lkdestport_i),
        .pop_i            (pop_i),
        .destport_o       (destport_o),
        .destport_valid_o (destport_valid_o),
        .full_o           (full_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en_i = 1'b0; hdr_flg_i = 1'b0; vc_num_i = '0; lkdestport_i = '0; pop_i = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic hdr(input logic [3:0] vc, input logic [3:0] dp);
        wr_en_i = 1'b1; hdr_flg_i = 1'b1; vc_num_i = vc; lkdestport_i = dp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        check("rst_destport", destport_o, 16'h0000);
        check("rst_valid", destport_valid_o, 4'b0000);
        check("rst_full", full_o, 4'b0000);
        check("rst_err", err_o, 1'b0);

        // 1: single push on VC0
        hdr(4'b0001, 4'h3); step();
        check("t1_valid", destport_valid_o, 4'b0001);
        check("t1_dp0", destport_o[3:0], 4'h3);
        check("t1_err", err_o, 1'b0);

        // 2: fill VC1, pop twice
        hdr(4'b0010, 4'h5); step();
        hdr(4'b0010, 4'h2); step();
        check("t2_full", full_o, 4'b0010);
        check("t2_valid", destport_valid_o, 4'b0011);
        check("t2_head5", destport_o[7:4], 4'h5);
        pop_i = 4'b0010; step();
        check("t2_head2", destport_o[7:4], 4'h2);
        check("t2_notfull", full_o, 4'b0000);
        pop_i = 4'b0010; step();
        check("t2_empty", destport_valid_o, 4'b0001);

        // 3: VC2 full, push+pop same cycle, then overflow
        hdr(4'b0100, 4'h8); step();
        hdr(4'b0100, 4'h9); step();
        check("t3_full", full_o, 4'b0100);
        hdr(4'b0100, 4'h7); pop_i = 4'b0100; step();
        check("t3_pp_full", full_o, 4'b0100);
        check("t3_pp_head", destport_o[11:8], 4'h9);
        check("t3_pp_err", err_o, 1'b0);
        hdr(4'b0100, 4'hA); step();
        check("t3_ovf_err", err_o, 1'b1);
        check("t3_ovf_full", full_o, 4'b0100);
        check("t3_ovf_head", destport_o[11:8], 4'h9);
        pop_i = 4'b0100; step();
        check("t3_next7", destport_o[11:8], 4'h7);
        pop_i = 4'b0100; step();
        check("t3_drained", destport_valid_o, 4'b0001);

        // 4: pop on empty VC3, error stays sticky
        do_reset();
        check("t4_rst_err", err_o, 1'b0);
        pop_i = 4'b1000; step();
        check("t4_err", err_o, 1'b1);
        check("t4_valid", destport_valid_o, 4'b0000);
        hdr(4'b1000, 4'h6); step();
        check("t4_sticky", err_o, 1'b1);
        check("t4_dp3", destport_o[15:12], 4'h6);
        check("t4_valid3", destport_valid_o, 4'b1000);
        // pop-empty plus push on the same VC: push accepted, error raised
        do_reset();
        hdr(4'b0001, 4'h4); pop_i = 4'b0001; step();
        check("t4_pe_valid", destport_valid_o, 4'b0001);
        check("t4_pe_dp", destport_o, 16'h0004);
        check("t4_pe_err", err_o, 1'b1);

        // 5: multi-hot VC and non-header flits
        do_reset();
        hdr(4'b0011, 4'h5); step();
        check("t5_multi_valid", destport_valid_o, 4'b0000);
        check("t5_multi_err", err_o, 1'b1);
        do_reset();
        wr_en_i = 1'b1; hdr_flg_i = 1'b0; vc_num_i = 4'b1000; lkdestport_i = 4'hF; step();
        check("t5_body_valid", destport_valid_o, 4'b0000);
        hdr(4'b0000, 4'hF); step();
        check("t5_novc_valid", destport_valid_o, 4'b0000);
        check("t5_novc_err", err_o, 1'b0);

        // 6: fill all VCs, independent ops, then reset mid-traffic
        for (int i = 0; i < 4; i++) begin
            hdr(4'(1 << i), 4'(i + 1)); step();
            hdr(4'(1 << i), 4'(i + 9)); step();
        end
        check("t6_full", full_o, 4'b1111);
        check("t6_dp", destport_o, 16'h4321);
        pop_i = 4'b0101; step();
        check("t6_pop02_dp", destport_o, 16'h4B29);
        check("t6_pop02_full", full_o, 4'b1010);
        hdr(4'b0001, 4'h5); pop_i = 4'b0010; step();
        check("t6_indep_dp", destport_o, 16'h4BA9);
        check("t6_indep_full", full_o, 4'b1001);
        check("t6_indep_err", err_o, 1'b0);
        do_reset();
        check("t6_rst_dp", destport_o, 16'h0000);
        check("t6_rst_valid", destport_valid_o, 4'b0000);
        check("t6_rst_full", full_o, 4'b0000);
        check("t6_rst_err", err_o, 1'b0);
        hdr(4'b0100, 4'hE); step();
        check("t6_post_valid", destport_valid_o, 4'b0100);
        check("t6_post_dp", destport_o, 16'h0E00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
